// File: rtl/lfsr_stepper.sv
// Button-driven Galois LFSR with hold, single-step, divided-run and full-rate modes, seed load, lock-up recovery and period measurement.
// Latency: a clean press reaches out after 2+DEB_CYCLES+1 clocks; free-run steps land one clock after the divider hit. No backpressure: every event is consumed at once.
// Optional LFSR_REVERSE_EN: mode 11 becomes reverse-step-on-button instead of full-rate forward run.

module lfsr_stepper_btn #(
    parameter int DEB_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic i_btn,
    output logic o_ev
);
    logic        r_s1;
    logic        r_s2;
    logic        r_lvl;
    logic        r_lvl_q;
    logic [15:0] r_cnt;

    // Level only moves after DEB_CYCLES consecutive disagreeing samples; any agreement restarts.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_s1    <= 1'b0;
            r_s2    <= 1'b0;
            r_lvl   <= 1'b0;
            r_lvl_q <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_s1    <= i_btn;
            r_s2    <= r_s1;
            r_lvl_q <= r_lvl;
            if (r_s2 != r_lvl) begin
                if (r_cnt == 16'(DEB_CYCLES - 1)) begin
                    r_lvl <= r_s2;
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + 16'd1;
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign o_ev = r_lvl & ~r_lvl_q;
endmodule

module lfsr_stepper #(
    parameter int               WIDTH      = 8,
    parameter logic [WIDTH-1:0] TAPS       = 8'hB8,
    parameter int               SEED       = 1,
    parameter int               DEB_CYCLES = 16,
    parameter int               DIV        = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             btn_step,
    input  logic             btn_load,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] seed_in,
    output logic [WIDTH-1:0] out,
    output logic             step_pulse,
    output logic             lockup,
    output logic             period_done,
    output logic [15:0]      period
);
    localparam logic [WIDTH-1:0] SEED_V = WIDTH'(SEED);

    logic             w_step_ev;
    logic             w_load_ev;
    logic             w_div_hit;
    logic             w_fwd;
    logic [WIDTH-1:0] w_fwd_nxt;

    logic [WIDTH-1:0] r_out;
    logic [WIDTH-1:0] r_ref;
    logic [15:0]      r_cnt;
    logic [15:0]      r_div;
    logic [15:0]      r_period;
    logic             r_step_pulse;
    logic             r_lockup;
    logic             r_period_done;

    lfsr_stepper_btn #(.DEB_CYCLES(DEB_CYCLES)) u_btn_step (
        .clk   (clk),
        .rst   (rst),
        .i_btn (btn_step),
        .o_ev  (w_step_ev)
    );

    lfsr_stepper_btn #(.DEB_CYCLES(DEB_CYCLES)) u_btn_load (
        .clk   (clk),
        .rst   (rst),
        .i_btn (btn_load),
        .o_ev  (w_load_ev)
    );

    assign w_div_hit = (r_div == 16'(DIV - 1));
    assign w_fwd_nxt = (r_out >> 1) ^ (r_out[0] ? TAPS : '0);

`ifdef LFSR_REVERSE_EN
    logic             w_rev;
    logic [WIDTH-1:0] w_rev_mix;
    logic [WIDTH-1:0] w_rev_nxt;

    assign w_rev_mix = r_out ^ (r_out[WIDTH-1] ? TAPS : '0);
    assign w_rev_nxt = {w_rev_mix[WIDTH-2:0], r_out[WIDTH-1]};

    always_comb begin
        w_fwd = 1'b0;
        w_rev = 1'b0;
        case (mode)
            2'b01:   w_fwd = w_step_ev;
            2'b10:   w_fwd = w_div_hit;
            2'b11:   w_rev = w_step_ev;
            default: ;
        endcase
    end
`else
    always_comb begin
        w_fwd = 1'b0;
        case (mode)
            2'b01:   w_fwd = w_step_ev;
            2'b10:   w_fwd = w_div_hit;
            2'b11:   w_fwd = 1'b1;
            default: ;
        endcase
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_div <= '0;
        end else if (mode != 2'b10 || w_div_hit) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + 16'd1;
        end
    end

    // Priority: load, then zero-state recovery, then any step.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_out         <= SEED_V;
            r_ref         <= SEED_V;
            r_cnt         <= '0;
            r_period      <= '0;
            r_step_pulse  <= 1'b0;
            r_lockup      <= 1'b0;
            r_period_done <= 1'b0;
        end else begin
            r_step_pulse  <= 1'b0;
            r_period_done <= 1'b0;
            if (w_load_ev) begin
                r_cnt <= '0;
                if (seed_in != '0) begin
                    r_out    <= seed_in;
                    r_ref    <= seed_in;
                    r_lockup <= 1'b0;
                end else begin
                    r_out    <= SEED_V;
                    r_ref    <= SEED_V;
                    r_lockup <= 1'b1;
                end
            end else if (r_out == '0) begin
                r_out    <= SEED_V;
                r_lockup <= 1'b1;
            end else if (w_fwd) begin
                r_out        <= w_fwd_nxt;
                r_step_pulse <= 1'b1;
                // A saturated counter freezes period reporting until the next load.
                if (r_cnt != 16'hFFFF) begin
                    if (w_fwd_nxt == r_ref) begin
                        r_period      <= r_cnt + 16'd1;
                        r_period_done <= 1'b1;
                        r_cnt         <= '0;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
            end
`ifdef LFSR_REVERSE_EN
            else if (w_rev) begin
                r_out        <= w_rev_nxt;
                r_step_pulse <= 1'b1;
                r_cnt        <= r_cnt - 16'd1;
            end
`endif
        end
    end

    assign out         = r_out;
    assign step_pulse  = r_step_pulse;
    assign lockup      = r_lockup;
    assign period_done = r_period_done;
    assign period      = r_period;
endmodule

// File: tb/tb_lfsr_stepper.sv
// Self-checking bench for lfsr_stepper: directed vector table, multi-cycle corner sequences and randomized runs against a step-rule model.
module tb_lfsr_stepper;
    localparam int        W  = 8;
    localparam logic [7:0] TP = 8'hB8;
    localparam int        DV = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       btn_step = 1'b0;
    logic       btn_load = 1'b0;
    logic [1:0] mode = 2'b00;
    logic [7:0] seed_in = 8'h00;
    logic [7:0] dut_out;
    logic       step_pulse;
    logic       lockup;
    logic       period_done;
    logic [15:0] period;

    always #5 clk = ~clk;

    lfsr_stepper #(
        .WIDTH(W), .TAPS(TP), .SEED(1), .DEB_CYCLES(4), .DIV(DV)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_step   (btn_step),
        .btn_load   (btn_load),
        .mode       (mode),
        .seed_in    (seed_in),
        .out        (dut_out),
        .step_pulse (step_pulse),
        .lockup     (lockup),
        .period_done(period_done),
        .period     (period)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] fstep(input logic [7:0] x);
        return (x >> 1) ^ ((x % 2 == 1) ? TP : 8'h00);
    endfunction

    function automatic int model_period(input logic [7:0] s);
        logic [7:0] x;
        int n;
        x = s;
        n = 0;
        do begin
            x = fstep(x);
            n++;
        end while (x != s && n < 70000);
        return n;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset(input logic [1:0] m);
        @(negedge clk);
        rst      = 1'b0;
        mode     = m;
        btn_step = 1'b0;
        btn_load = 1'b0;
        tick(2);
        rst = 1'b1;
    endtask

    int         pulses;
    logic [7:0] out_b6;
    logic [7:0] out_a7;
    logic       pulse_a7;

    task automatic press(input bit is_load);
        pulses = 0;
        if (is_load) btn_load = 1'b1; else btn_step = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (step_pulse) pulses++;
            if (i == 6) out_b6 = dut_out;
            if (i == 7) begin
                out_a7   = dut_out;
                pulse_a7 = step_pulse;
            end
        end
        btn_load = 1'b0;
        btn_step = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (step_pulse) pulses++;
        end
    endtask

    task automatic run_steps(input int n);
`ifdef LFSR_REVERSE_EN
        mode = 2'b10;
        tick(n * DV);
`else
        mode = 2'b11;
        tick(n);
`endif
        mode = 2'b00;
    endtask

    task automatic wait_period(output int k);
        k = 0;
        while (k < 400) begin
            @(negedge clk);
            k++;
            if (period_done) break;
        end
    endtask

    typedef struct {
        logic [7:0] seed;
        int         steps;
        logic [7:0] exp_out;
        logic       exp_lock;
    } vec_t;

    vec_t tbl[7];

    initial begin
        logic [7:0] prev;
        logic [7:0] x;
        logic [7:0] s;
        logic [7:0] seq[4];
        logic [1:0] m;
        int         n;
        int         k;
        bit         stepped;

        tbl[0] = '{8'h01, 4, 8'h17, 1'b0};
        tbl[1] = '{8'h17, 2, 8'hE1, 1'b0};
        tbl[2] = '{8'hB3, 2, 8'hC8, 1'b0};
        tbl[3] = '{8'hC8, 3, 8'h19, 1'b0};
        tbl[4] = '{8'h00, 1, 8'hB8, 1'b1};
        tbl[5] = '{8'h32, 2, 8'hB4, 1'b0};
        tbl[6] = '{8'h5C, 0, 8'h5C, 1'b0};
        seq[0] = 8'hB8; seq[1] = 8'h5C; seq[2] = 8'h2E; seq[3] = 8'h17;

        // Reset values
        rst = 1'b0;
        tick(2);
        chk("reset_out", dut_out, 8'h01);
        chk("reset_step_pulse", step_pulse, 1'b0);
        chk("reset_lockup", lockup, 1'b0);
        chk("reset_period_done", period_done, 1'b0);
        chk("reset_period", period, 16'h0);

        // Four clean presses in single-step mode
        do_reset(2'b01);
        prev = 8'h01;
        for (int i = 0; i < 4; i++) begin
            press(1'b0);
            chk($sformatf("step%0d_before_latency", i), out_b6, prev);
            chk($sformatf("step%0d_out", i), out_a7, seq[i]);
            chk($sformatf("step%0d_pulse_aligned", i), pulse_a7, 1'b1);
            chk($sformatf("step%0d_pulse_count", i), pulses, 1);
            prev = seq[i];
        end

        // Bouncing button: only the final stable level counts
        do_reset(2'b01);
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            btn_step = ((i / 2) % 2 == 1);
            @(negedge clk);
            if (step_pulse) pulses++;
        end
        btn_step = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (step_pulse) pulses++;
        end
        btn_step = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (step_pulse) pulses++;
        end
        chk("bounce_pulse_count", pulses, 1);
        chk("bounce_out", dut_out, 8'hB8);

`ifndef LFSR_REVERSE_EN
        // Full-rate run from reset returns to seed after a full period
        do_reset(2'b11);
        wait_period(k);
        chk("fullrate_period_cycles", k, 255);
        chk("fullrate_period", period, 16'd255);
        chk("fullrate_out_at_pulse", dut_out, 8'h01);
        tick(1);
        chk("fullrate_period_done_one_cycle", period_done, 1'b0);
`endif

        // Divided run
        do_reset(2'b10);
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            chk($sformatf("div_pulse_clk%0d", i), step_pulse, (i % DV == 0));
        end
        chk("div_out_after_8", dut_out, 8'h5C);

        // Zero seed rejected, then a good seed clears lockup; hold mode keeps out
        do_reset(2'b00);
        seed_in = 8'h00;
        press(1'b1);
        chk("load_zero_out", dut_out, 8'h01);
        chk("load_zero_lockup", lockup, 1'b1);
        chk("load_no_pulse", pulses, 0);
        seed_in = 8'h17;
        press(1'b1);
        chk("load_seed_out", dut_out, 8'h17);
        chk("load_seed_lockup", lockup, 1'b0);
        tick(10);
        chk("hold_out", dut_out, 8'h17);

        // Vector table: load seed, run N steps
        for (int i = 0; i < 7; i++) begin
            mode    = 2'b00;
            seed_in = tbl[i].seed;
            press(1'b1);
            run_steps(tbl[i].steps);
            chk($sformatf("vec%0d_out", i), dut_out, tbl[i].exp_out);
            chk($sformatf("vec%0d_lockup", i), lockup, tbl[i].exp_lock);
        end

        // Randomized runs against the step-rule model
        for (int r = 0; r < 12; r++) begin
            s       = 8'($urandom_range(1, 255));
            mode    = 2'b00;
            seed_in = s;
            press(1'b1);
            chk($sformatf("rnd%0d_load", r), dut_out, s);
`ifdef LFSR_REVERSE_EN
            m = 2'b10;
`else
            m = ($urandom_range(0, 1) == 1) ? 2'b11 : 2'b10;
`endif
            n    = $urandom_range(5, 40);
            x    = s;
            mode = m;
            for (int c = 1; c <= n; c++) begin
                @(negedge clk);
                stepped = (m == 2'b11) || (c % DV == 0);
                if (stepped) x = fstep(x);
                chk($sformatf("rnd%0d_c%0d_out", r, c), dut_out, x);
                chk($sformatf("rnd%0d_c%0d_pulse", r, c), step_pulse, stepped);
            end
            mode = 2'b00;
        end

`ifndef LFSR_REVERSE_EN
        // Period measurement from random seeds
        for (int r = 0; r < 3; r++) begin
            s       = 8'($urandom_range(1, 255));
            mode    = 2'b00;
            seed_in = s;
            press(1'b1);
            mode = 2'b11;
            wait_period(k);
            chk($sformatf("rper%0d_cycles", r), k, model_period(s));
            chk($sformatf("rper%0d_period", r), period, 16'(model_period(s)));
            chk($sformatf("rper%0d_out", r), dut_out, s);
            mode = 2'b00;
        end
`else
        // Reverse stepping on button in mode 11
        do_reset(2'b00);
        seed_in = 8'hB3;
        press(1'b1);
        mode = 2'b11;
        press(1'b0);
        chk("rev1_out", dut_out, 8'h17);
        chk("rev1_pulses", pulses, 1);
        press(1'b0);
        chk("rev2_out", dut_out, 8'h2E);
        mode = 2'b00;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/lfsr_stepper.md
Name: lfsr_stepper

Overview:
- Parametrised successor to the 8-bit button-clocked PRBS generator. Runs entirely on the board clock; step/load buttons enter through synchronisers and debouncers, never as clocks.
- Galois LFSR of configurable width and taps. Modes: hold, single-step, divided free-run, full-rate free-run.
- Adds seed load, all-zero lock-up recovery and period measurement.
- Output feeds the hex display decoders and LEDs in the board top level.

Parameters:
- WIDTH, 8, LFSR width; legal 4..16.
- TAPS, 8'hB8, Galois feedback mask, WIDTH bits; bit WIDTH-1 must be 1.
- SEED, 1, reset and lock-up recovery value; must be non-zero.
- DEB_CYCLES, 16, consecutive stable cycles required to accept a button level change; legal 2..65535.
- DIV, 4, clocks per step in mode 2'b10; legal 1..65535.

Ports:
- clk, input, 1, sole clock; all logic rising-edge.
- rst, input, 1, asynchronous active-low reset.
- btn_step, input, 1, raw asynchronous step button.
- btn_load, input, 1, raw asynchronous load button.
- mode, input, 2, 00 hold, 01 step-on-button, 10 divided run, 11 full-rate run.
- seed_in, input, WIDTH, value loaded on a load event.
- out, output, WIDTH, current LFSR state.
- step_pulse, output, 1, high for one cycle when out advanced.
- lockup, output, 1, sticky flag: a zero seed was rejected.
- period_done, output, 1, one-cycle pulse when the state returns to the last loaded value.
- period, output, 16, step count of the last completed cycle.

Behaviour:
- Reset (rst=0, asynchronous): out=SEED, step_pulse=0, lockup=0, period_done=0, period=0; step counter=0; reference register=SEED; divider=0; sync and debounce state=0.
- Input path: 2-FF synchroniser per button. The debounced level changes only after the synced level differs from it for DEB_CYCLES consecutive clocks; any bounce restarts the count. A rising edge of the debounced level gives a one-cycle event (step_ev, load_ev).
- Latency from a clean button press to the out update is 2 + DEB_CYCLES + 1 clocks.
- Forward step (Galois, right shift): out <= (out>>1) ^ (out[0] ? TAPS : 0).
- Stepping by mode:
  - 00: no stepping.
  - 01: one step per step_ev.
  - 10: one step when the divider reaches DIV-1; the divider then wraps to 0. The divider is cleared when mode is not 10.
  - 11: one step every clock.
- step_pulse is asserted in the cycle after each step, aligned with the new out.
- Load (load_ev):
  - If seed_in != 0: out <= seed_in and reference <= seed_in.
  - If seed_in == 0: out <= SEED, reference <= SEED, lockup <= 1.
  - Step counter is cleared on every load. A load with a non-zero seed clears lockup.
- Load has priority over a step in the same cycle; that step is dropped and step_pulse stays 0.
- Lock-up guard: if out is ever 0 (illegal TAPS), the next cycle forces out <= SEED and sets lockup. No step occurs in that cycle.
- Period measurement:
  - The step counter increments on each step and saturates at 16'hFFFF.
  - When a step produces out == reference: period <= counter+1, period_done=1 for one cycle, counter <= 0.
  - If the counter saturates, period is never updated and the counter holds until the next load.
- Mode changes take effect on the next clock; a pending debounce is unaffected.

Optional Feature:
- Macro LFSR_REVERSE_EN.
- Defined: mode 11 becomes reverse-step-on-button. Each step_ev applies the inverse step: p0 = out[WIDTH-1]; out <= ((out ^ (p0 ? TAPS : 0)) << 1) | p0, truncated to WIDTH bits. step_pulse fires as for a forward step. The step counter decrements, wrapping 0 to 16'hFFFF. period_done is suppressed in reverse steps.
- Not defined: mode 11 is full-rate forward run; no inverse logic is built.

Test Plan:
- Bench parameters for all scenarios: WIDTH=8, TAPS=8'hB8, SEED=1, DEB_CYCLES=4, DIV=4.
- Reset, mode=01, four clean step presses -> out sequence 8'h01, 8'hB8, 8'h5C, 8'h2E, 8'h17; one step_pulse per press. Each update occurs 7 clocks after the press edge.
- Bounce btn_step 0/1 every 2 clocks for 20 clocks, then hold high -> exactly one step; out goes 8'h01 to 8'hB8.
- mode=11 from reset -> period_done after 255 clocks, period=255, out=8'h01 at the pulse.
- mode=10 -> step_pulse every 4th clock; out=8'h5C after 8 clocks.
- seed_in=0, press load -> out=8'h01, lockup=1. Then seed_in=8'h17, press load -> out=8'h17, lockup=0.
- LFSR_REVERSE_EN, out=8'hB3, mode=11, one step press -> out=8'h17. A second press -> out=8'h2E.
